// File: rtl/gpo_timed_fifo.sv
// Timestamped event FIFO feeding a GPO core: the head entry is issued when its
// timestamp equals the global counter, or dropped if it is already late.
// Optional macro GPO_TIMED_FIFO_LATE_COUNT_EN enables the saturating late_count.
module gpo_timed_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           counter,
  input  logic                  wr_en,
  input  logic [127:0]          wr_data,
  input  logic                  flush,
  input  logic                  busy,
  output logic [127:0]          gpo_in,
  output logic                  counter_matched,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow_error,
  output logic                  late_error,
  output logic [15:0]           late_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    HEAD_IDLE,
    HEAD_WAIT,
    HEAD_FIRE,
    HEAD_LATE
  } head_e;

  logic [127:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [127:0]          gpo_in_q, gpo_in_d;
  logic                  matched_q, matched_d;
  logic                  overflow_q, overflow_d;
  logic                  late_q, late_d;

  head_e                 head_state;
  logic [127:0]          head_entry;
  logic [TS_WIDTH-1:0]   head_ts;
  logic [TS_WIDTH-1:0]   now_ts;
  logic                  fire_pop;
  logic                  late_pop;
  logic                  pop;
  logic                  push;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign head_entry = mem_q[rd_ptr_q];
  assign head_ts    = head_entry[64 +: TS_WIDTH];
  assign now_ts     = counter[TS_WIDTH-1:0];

  // Head classification; an empty FIFO never compares.
  always_comb begin
    head_state = HEAD_IDLE;
    if (!empty) begin
      if (head_ts > now_ts)       head_state = HEAD_WAIT;
      else if (head_ts == now_ts) head_state = HEAD_FIRE;
      else                        head_state = HEAD_LATE;
    end
  end

  // Flush overrides every pop and push in its cycle.
  assign fire_pop = !flush && (head_state == HEAD_FIRE) && !busy;
  assign late_pop = !flush && (head_state == HEAD_LATE);
  assign pop      = fire_pop || late_pop;
  assign push     = !flush && wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    gpo_in_d   = gpo_in_q;
    matched_d  = 1'b0;
    late_d     = late_pop;
    overflow_d = !flush && wr_en && full && !pop;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (fire_pop) begin
        gpo_in_d  = head_entry;
        matched_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gpo_in_q   <= '0;
      matched_q  <= 1'b0;
      overflow_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gpo_in_q   <= gpo_in_d;
      matched_q  <= matched_d;
      overflow_q <= overflow_d;
      late_q     <= late_d;
    end
  end

  // Storage is not reset so it can map onto RAM; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef GPO_TIMED_FIFO_LATE_COUNT_EN
  logic [15:0] late_cnt_q, late_cnt_d;

  always_comb begin
    late_cnt_d = late_cnt_q;
    if (late_pop && late_cnt_q != 16'hFFFF) late_cnt_d = late_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) late_cnt_q <= '0;
    else       late_cnt_q <= late_cnt_d;
  end

  assign late_count = late_cnt_q;
`else
  assign late_count = 16'd0;
`endif

  assign gpo_in          = gpo_in_q;
  assign counter_matched = matched_q;
  assign count           = count_q;
  assign overflow_error  = overflow_q;
  assign late_error      = late_q;

endmodule
